// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-stage control and address bus.
//   master : driven by pc_fetch_unit (addr, addr_valid, pc_plus4, fetch_count,
//            misalign_err, state); receives en, stall, redirect_valid/target.
//   slave  : the consumer side (pipeline control / instruction memory).
interface pc_fetch_if;
  logic        en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] addr;
  logic        addr_valid;
  logic [31:0] pc_plus4;
  logic [15:0] fetch_count;
  logic        misalign_err;
  logic [1:0]  state;

  modport master (
    input  en, stall, redirect_valid, redirect_target,
    output addr, addr_valid, pc_plus4, fetch_count, misalign_err, state
  );

  modport slave (
    output en, stall, redirect_valid, redirect_target,
    input  addr, addr_valid, pc_plus4, fetch_count, misalign_err, state
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer feeding the instruction
// memory. Produces a word-aligned fetch address each cycle, with stall hold,
// branch/jump redirect and an optional misaligned-target trap.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> TRAP).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pc_fetch_if.master (en, stall, redirect in; addr, addr_valid,
//            pc_plus4 (combinational), fetch_count, misalign_err, state out)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_fetch_if.master   bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    TRAP  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            valid_q;
  logic [AW-1:0]   target_c;
  logic            trap_c;

  // Low target bits are dropped so addr stays word aligned in every mode.
  assign target_c = bus.redirect_target & ~AW'(3);

`ifdef PC_MISALIGN_TRAP_EN
  assign trap_c = |bus.redirect_target[1:0];
`else
  assign trap_c = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= RESET_VECTOR;
      count_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      valid_q <= (state_d == RUN);
    end
  end

  // Next state / next address. Priority: en, redirect, stall, increment.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;

    // A fetch is consumed on every unstalled RUN cycle.
    if (state_q == RUN && !bus.stall) begin
      count_d = count_q + CW'(1);
    end

    if (!bus.en) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      // First fetch is the held address; redirects are ignored here.
      state_d = bus.stall ? STALL : RUN;
    end else if (bus.redirect_valid) begin
      if (trap_c) begin
        state_d = TRAP;
        addr_d  = TRAP_VECTOR;
        err_d   = 1'b1;
      end else begin
        addr_d  = target_c;
        state_d = bus.stall ? STALL : RUN;
      end
    end else if (bus.stall) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
      // Leaving STALL refetches the held address; RUN and TRAP advance.
      if (state_q != STALL) begin
        addr_d = addr_q + AW'(4);
      end
    end
  end

  assign bus.addr         = addr_q;
  assign bus.addr_valid   = valid_q;
  assign bus.pc_plus4     = addr_q + AW'(4);
  assign bus.fetch_count  = count_q;
  assign bus.misalign_err = err_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed test of pc_fetch_unit with two instances, one at
// default vectors and one with RESET_VECTOR near the top of the address space.
module tb_pc_fetch_unit;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   n_checks;
  int   n_fail;
  int   edge_n;

  pc_fetch_if bus1 ();
  pc_fetch_if bus2 ();

  pc_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_hi (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " addr"},  bus1.addr, 32'h0);
    chk({tag, " valid"}, 32'(bus1.addr_valid), 32'h0);
    chk({tag, " count"}, 32'(bus1.fetch_count), 32'h0);
    chk({tag, " err"},   32'(bus1.misalign_err), 32'h0);
    chk({tag, " state"}, 32'(bus1.state), 32'h0);
    chk({tag, " plus4"}, bus1.pc_plus4, 32'h4);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    rst_n    = 1'b0;
    rst2_n   = 1'b0;
    bus1.en = 1'b0; bus1.stall = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_target = '0;
    bus2.en = 1'b0; bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_target = '0;

    step(); step();
    chk_reset_vals("reset");

    rst_n = 1'b1; rst2_n = 1'b1;
    bus1.en = 1'b1; bus2.en = 1'b1;
    edge_n = 0;

    // Edges 1..5: IDLE->RUN then sequential fetch.
    step();
    chk("run1 addr",  bus1.addr, 32'h0);
    chk("run1 valid", 32'(bus1.addr_valid), 32'h1);
    chk("run1 state", 32'(bus1.state), 32'h1);
    chk("run1 count", 32'(bus1.fetch_count), 32'h0);
    chk("hi1 addr",   bus2.addr, 32'hFFFF_FFF8);
    step();
    chk("run2 addr",  bus1.addr, 32'h4);
    chk("hi2 addr",   bus2.addr, 32'hFFFF_FFFC);
    chk("hi2 plus4",  bus2.pc_plus4, 32'h0);
    step();
    chk("run3 addr",  bus1.addr, 32'h8);
    chk("hi3 addr",   bus2.addr, 32'h0);
    step();
    chk("run4 addr",  bus1.addr, 32'hC);
    chk("run4 count", 32'(bus1.fetch_count), 32'h3);
    step();
    chk("run5 addr",  bus1.addr, 32'h10);
    chk("run5 count", 32'(bus1.fetch_count), 32'h4);

    // Redirect from 0x10 to 0x200.
    bus1.redirect_valid = 1'b1; bus1.redirect_target = 32'h200;
    step();
    bus1.redirect_valid = 1'b0;
    chk("redir addr",  bus1.addr, 32'h200);
    chk("redir plus4", bus1.pc_plus4, 32'h204);
    step();
    chk("redir+1 addr",  bus1.addr, 32'h204);
    chk("redir+1 plus4", bus1.pc_plus4, 32'h208);
    chk("redir+1 count", 32'(bus1.fetch_count), 32'h6);

    // Get to 0x20, then stall three cycles with a redirect in the second.
    bus1.redirect_valid = 1'b1; bus1.redirect_target = 32'h20;
    step();
    bus1.redirect_valid = 1'b0;
    chk("to20 addr", bus1.addr, 32'h20);
    bus1.stall = 1'b1;
    step();
    chk("stall1 addr",  bus1.addr, 32'h20);
    chk("stall1 state", 32'(bus1.state), 32'h2);
    chk("stall1 valid", 32'(bus1.addr_valid), 32'h0);
    chk("stall1 count", 32'(bus1.fetch_count), 32'h7);
    bus1.redirect_valid = 1'b1; bus1.redirect_target = 32'h300;
    step();
    bus1.redirect_valid = 1'b0;
    chk("stall2 addr",  bus1.addr, 32'h300);
    chk("stall2 state", 32'(bus1.state), 32'h2);
    step();
    chk("stall3 addr",  bus1.addr, 32'h300);
    chk("stall3 count", 32'(bus1.fetch_count), 32'h7);
    bus1.stall = 1'b0;
    step();
    chk("unstall addr",  bus1.addr, 32'h300);
    chk("unstall state", 32'(bus1.state), 32'h1);
    chk("unstall valid", 32'(bus1.addr_valid), 32'h1);
    chk("unstall count", 32'(bus1.fetch_count), 32'h7);
    step();
    chk("unstall+1 addr",  bus1.addr, 32'h304);
    chk("unstall+1 count", 32'(bus1.fetch_count), 32'h8);

    // Misaligned redirect to 0x202.
    bus1.redirect_valid = 1'b1; bus1.redirect_target = 32'h202;
    step();
    bus1.redirect_valid = 1'b0;
    chk("mis addr",  bus1.addr, TRAP_EN ? 32'h100 : 32'h200);
    chk("mis state", 32'(bus1.state), TRAP_EN ? 32'h3 : 32'h1);
    chk("mis valid", 32'(bus1.addr_valid), TRAP_EN ? 32'h0 : 32'h1);
    chk("mis err",   32'(bus1.misalign_err), TRAP_EN ? 32'h1 : 32'h0);
    chk("mis count", 32'(bus1.fetch_count), 32'h9);
    step();
    chk("mis+1 addr",  bus1.addr, TRAP_EN ? 32'h104 : 32'h204);
    chk("mis+1 state", 32'(bus1.state), 32'h1);
    chk("mis+1 err",   32'(bus1.misalign_err), TRAP_EN ? 32'h1 : 32'h0);
    chk("mis+1 count", 32'(bus1.fetch_count), TRAP_EN ? 32'h9 : 32'hA);

    // en low parks in IDLE with addr held.
    bus1.en = 1'b0;
    step();
    chk("idle state", 32'(bus1.state), 32'h0);
    chk("idle valid", 32'(bus1.addr_valid), 32'h0);
    chk("idle addr",  bus1.addr, TRAP_EN ? 32'h104 : 32'h204);
    chk("idle err",   32'(bus1.misalign_err), TRAP_EN ? 32'h1 : 32'h0);

    // Redirect presented while leaving IDLE is ignored.
    bus1.en = 1'b1; bus1.redirect_valid = 1'b1; bus1.redirect_target = 32'h500;
    step();
    bus1.redirect_valid = 1'b0;
    chk("wake state", 32'(bus1.state), 32'h1);
    chk("wake addr",  bus1.addr, TRAP_EN ? 32'h104 : 32'h204);

    // Asynchronous reset between edges, no clock needed.
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");

    // Release into IDLE with stall high: IDLE -> STALL -> RUN.
    bus1.stall = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("istall state", 32'(bus1.state), 32'h2);
    chk("istall addr",  bus1.addr, 32'h0);
    chk("istall valid", 32'(bus1.addr_valid), 32'h0);
    bus1.stall = 1'b0;
    step();
    chk("irun state", 32'(bus1.state), 32'h1);
    chk("irun addr",  bus1.addr, 32'h0);
    chk("irun count", 32'(bus1.fetch_count), 32'h0);
    step();
    chk("irun+1 addr",  bus1.addr, 32'h4);
    chk("irun+1 count", 32'(bus1.fetch_count), 32'h1);

    // Free-running instance: fetch_count wraps after 65536 fetches.
    while (edge_n < 65536) step();
    chk("wrap pre count", 32'(bus2.fetch_count), 32'hFFFF);
    step();
    chk("wrap count", 32'(bus2.fetch_count), 32'h0);
    chk("wrap addr",  bus2.addr, 32'h0003_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
